// File: rtl/pwm_frec_gen.sv
// PWM generator with a power-of-two tick prescaler selected by a 3-bit frequency code.
// The frequency code and duty are shadowed and only change at a period boundary.
module pwm_frec_gen #(
  parameter int unsigned PRESC_BASE = 50,
  parameter int unsigned PRESC_W    = 16,
  parameter int unsigned DUTY_W     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [2:0]        frec_in,
  input  logic [DUTY_W-1:0] duty_in,
  output logic              pwm_out,
  output logic              period_start,
  output logic [2:0]        frec_active
);

  localparam logic [PRESC_W-1:0] Base = PRESC_W'(PRESC_BASE);

  logic [PRESC_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [DUTY_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [2:0]         frec_active_q, frec_active_d;
  logic [DUTY_W-1:0]  duty_act_q, duty_act_d;
  logic               en_q, en_d;
  logic               pwm_out_q, pwm_out_d;
  logic               period_start_q, period_start_d;

  logic [PRESC_W-1:0] limit;
  logic               tick;
  logic               wrap;

  // At code 0 the shifted base may equal 2**PRESC_W and wrap to 0; the -1 still yields all-ones.
  assign limit = (Base << (3'd7 - frec_active_q)) - PRESC_W'(1);
  assign tick  = en_q && (pre_cnt_q == limit);
  assign wrap  = tick && (&pwm_cnt_q);

  always_comb begin
    pre_cnt_d      = pre_cnt_q;
    pwm_cnt_d      = pwm_cnt_q;
    frec_active_d  = frec_active_q;
    duty_act_d     = duty_act_q;
    en_d           = en_q;
    period_start_d = 1'b0;

    if (!enable) begin
      pre_cnt_d     = '0;
      pwm_cnt_d     = '0;
      frec_active_d = frec_in;
      duty_act_d    = duty_in;
      en_d          = 1'b0;
    end else if (!en_q) begin
      en_d           = 1'b1;
      period_start_d = 1'b1;
      pre_cnt_d      = '0;
      pwm_cnt_d      = '0;
    end else begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + PRESC_W'(1);
      if (tick) begin
        pwm_cnt_d = pwm_cnt_q + DUTY_W'(1);
      end
      if (wrap) begin
        frec_active_d  = frec_in;
        duty_act_d     = duty_in;
        period_start_d = 1'b1;
      end
    end

    // Compare against next-state values so the output lines up with the registered counter.
    pwm_out_d = enable && (pwm_cnt_d < duty_act_d);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre_cnt_q      <= '0;
      pwm_cnt_q      <= '0;
      frec_active_q  <= 3'd0;
      duty_act_q     <= '0;
      en_q           <= 1'b0;
      pwm_out_q      <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      frec_active_q  <= frec_active_d;
      duty_act_q     <= duty_act_d;
      en_q           <= en_d;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= period_start_d;
    end
  end

  assign pwm_out      = pwm_out_q;
  assign period_start = period_start_q;
  assign frec_active  = frec_active_q;

endmodule

// File: tb/tb_pwm_frec_gen.sv
// Testbench for pwm_frec_gen: a period-level reference model feeds a scoreboard queue,
// and a monitor measures each observed period against it.
module tb_pwm_frec_gen;

  localparam int PB = 2;
  localparam int PW = 16;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [2:0]    frec_in = 3'd0;
  logic [DW-1:0] duty_in = '0;
  logic          pwm_out;
  logic          period_start;
  logic [2:0]    frec_active;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int f;
    int d;
  } exp_t;

  exp_t exp_q[$];

  always #5 clock = ~clock;

  pwm_frec_gen #(
    .PRESC_BASE(PB),
    .PRESC_W   (PW),
    .DUTY_W    (DW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .frec_in     (frec_in),
    .duty_in     (duty_in),
    .pwm_out     (pwm_out),
    .period_start(period_start),
    .frec_active (frec_active)
  );

  // Clock cycles per PWM tick for a frequency code.
  function automatic int unit_cyc(input int f);
    return PB << (7 - f);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_ps(input int max_cyc, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(posedge clock);
      #1;
      if (period_start) seen = 1'b1;
    end
    check({name, "_ps_seen"}, 32'(seen), 32'd1);
  endtask

  // Reference model: tracks position within a period of 256 ticks; samples inputs at boundaries.
  initial begin
    int  m_cyc;
    bit  m_en;
    int  m_f;
    int  m_d;
    exp_t e;
    m_cyc = 0;
    m_en  = 1'b0;
    m_f   = 0;
    m_d   = 0;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        m_en = 1'b0;
        m_f  = 0;
        m_d  = 0;
      end else if (!enable) begin
        m_en = 1'b0;
        m_f  = int'(frec_in);
        m_d  = int'(duty_in);
      end else if (!m_en) begin
        m_en  = 1'b1;
        m_cyc = 0;
        e.f = m_f;
        e.d = m_d;
        exp_q.push_back(e);
      end else begin
        m_cyc++;
        if (m_cyc == 256 * unit_cyc(m_f)) begin
          m_cyc = 0;
          m_f   = int'(frec_in);
          m_d   = int'(duty_in);
          e.f = m_f;
          e.d = m_d;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Monitor: measures each complete period between period_start pulses.
  initial begin
    bit   meas;
    int   len;
    int   hi;
    exp_t cur;
    meas = 1'b0;
    len  = 0;
    hi   = 0;
    cur.f = 0;
    cur.d = 0;
    forever begin
      @(negedge clock);
      if (!reset || !enable) begin
        meas = 1'b0;
        exp_q.delete();
      end else if (period_start) begin
        if (meas) begin
          check("period_len", 32'(len), 32'(256 * unit_cyc(cur.f)));
          check("high_time", 32'(hi), 32'(cur.d * unit_cyc(cur.f)));
        end
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL exp_queue: got period_start with no expected period pending");
          meas = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          check("frec_active_at_start", 32'(frec_active), 32'(cur.f));
          meas = 1'b1;
          len  = 1;
          hi   = int'(pwm_out);
        end
      end else if (meas) begin
        len++;
        hi += int'(pwm_out);
      end
    end
  end

  initial begin
    int f;
    int d;

    // 1: reset state, async reset mid-run, shadows transparent while disabled
    step(1);
    check("rst_pwm_out", 32'(pwm_out), 32'd0);
    check("rst_period_start", 32'(period_start), 32'd0);
    check("rst_frec_active", 32'(frec_active), 32'd0);
    reset   = 1'b1;
    frec_in = 3'd7;
    duty_in = 8'd200;
    step(1);
    enable = 1'b1;
    step(300);
    check("t1_pwm_high_before_reset", 32'(pwm_out), 32'd1);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("t1_async_pwm_out", 32'(pwm_out), 32'd0);
    check("t1_async_period_start", 32'(period_start), 32'd0);
    check("t1_async_frec_active", 32'(frec_active), 32'd0);
    enable = 1'b0;
    step(2);
    reset   = 1'b1;
    frec_in = 3'd5;
    step(1);
    check("t1_track_5", 32'(frec_active), 32'd5);
    frec_in = 3'd2;
    step(1);
    check("t1_track_2", 32'(frec_active), 32'd2);

    // 2: frec 7, duty 64
    frec_in = 3'd7;
    duty_in = 8'd64;
    step(1);
    enable = 1'b1;
    wait_ps(5, "t2_start");
    for (int i = 0; i < 3; i++) wait_ps(600, "t2_period");

    // 3: slowest code, then a mid-period change to 7
    frec_in = 3'd0;
    duty_in = 8'd128;
    wait_ps(600, "t3_load_slow");
    step(1000);
    frec_in = 3'd7;
    check("t3_shadow_holds", 32'(frec_active), 32'd0);
    wait_ps(70000, "t3_slow_end");
    check("t3_frec_after_wrap", 32'(frec_active), 32'd7);
    wait_ps(600, "t3_fast");

    // 4: duty boundaries
    duty_in = 8'd0;
    wait_ps(600, "t4_load0");
    wait_ps(600, "t4_duty0");
    duty_in = 8'd255;
    wait_ps(600, "t4_load255");
    wait_ps(600, "t4_duty255");

    // 5: drop enable at cycle 300 of a period, then restart
    duty_in = 8'd200;
    wait_ps(600, "t5_load");
    step(299);
    check("t5_pwm_high_before_drop", 32'(pwm_out), 32'd1);
    enable  = 1'b0;
    frec_in = 3'd6;
    step(1);
    check("t5_pwm_low", 32'(pwm_out), 32'd0);
    check("t5_ps_low", 32'(period_start), 32'd0);
    check("t5_pwm_cnt_zero", 32'(dut.pwm_cnt_q), 32'd0);
    check("t5_pre_cnt_zero", 32'(dut.pre_cnt_q), 32'd0);
    step(1);
    check("t5_track_6", 32'(frec_active), 32'd6);
    frec_in = 3'd7;
    step(1);
    enable = 1'b1;
    step(1);
    check("t5_restart_ps", 32'(period_start), 32'd1);
    check("t5_restart_frec", 32'(frec_active), 32'd7);
    wait_ps(600, "t5_full_period");

    // 6: several changes within one period; only the wrap-cycle value counts
    step(100);
    frec_in = 3'd3;
    step(100);
    frec_in = 3'd4;
    step(100);
    frec_in = 3'd5;
    wait_ps(600, "t6_wrap");
    check("t6_frec_active", 32'(frec_active), 32'd5);
    wait_ps(2100, "t6_period5");

    // Randomised periods with mid-period disturbances
    for (int k = 0; k < 5; k++) begin
      f = int'($urandom_range(7, 5));
      d = int'($urandom_range(255, 0));
      step(int'($urandom_range(200, 1)));
      frec_in = 3'($urandom_range(7, 0));
      duty_in = 8'($urandom_range(255, 0));
      step(int'($urandom_range(200, 1)));
      frec_in = 3'(f);
      duty_in = 8'(d);
      wait_ps(2100, "rnd_wrap");
    end
    wait_ps(2100, "rnd_last");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
